// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   WORD_BYTES / PC_INC : sequential fetch stride
//   DEFAULT_RESET_PC    : default reset vector
//   fetch_entry_t       : buffered {pc, instr} pair
package instr_fetch_ctrl_pkg;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] PC_INC           = 32'(WORD_BYTES);
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// Synchronous instruction buffer (no fall-through).
//   clk, rst_n    : clock, async active-low reset
//   flush_i       : drop all entries (wins over push/pop)
//   push_i/data_i : write one entry at the tail
//   pop_i         : retire the head entry
//   head_o        : entry at the head (meaningful when count_o != 0)
//   count_o       : number of buffered entries
module instr_fetch_ctrl_fetch_fifo
    import instr_fetch_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    // Pointer/count next-state; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is qualified by count downstream
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer between IF and a 1-cycle registered-read instruction ROM.
//   imem_req/imem_addr/imem_rdata : ROM request (data returns next cycle)
//   redirect_valid/redirect_pc    : flush and re-steer fetch
//   if_valid/if_ready/if_instr/if_pc : buffered instruction stream to IF/ID
//   fetch_pc                      : next address to request (debug)
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_data;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credit check: buffered plus in-flight words never exceed the FIFO size
    assign issue = rst_n & ~redirect_valid
                 & ((count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));

    // A redirect kills the word returning this cycle
    assign push      = inflight_q & ~redirect_valid;
    assign push_data = '{pc: inflight_pc_q, instr: imem_rdata};
    assign pop       = if_valid & if_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_INC;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    instr_fetch_ctrl_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign if_valid  = (count != '0);
    assign if_instr  = if_valid ? head.instr : '0;
    assign if_pc     = if_valid ? head.pc    : '0;
    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed scenarios push expected
// requests and deliveries into queues; a negedge monitor pops and compares.
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] W0 = 32'h2004_0003;
    localparam logic [31:0] W1 = 32'h0c00_0003;
    localparam logic [31:0] W2 = 32'h1000_ffff;
    localparam logic [31:0] W3 = 32'h23bd_fff8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_pc;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  exp_req [$];
    fetch_entry_t exp_tx  [$];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_pc       (fetch_pc)
    );

    // ROM contents: four program words, otherwise address ^ 0xDEAD0000
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0: return W0;
            32'h4: return W1;
            32'h8: return W2;
            32'hC: return W3;
            default: return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    // Registered-read ROM
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_tx(input logic [31:0] pc, input logic [31:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_tx.push_back(e);
    endtask

    task automatic end_scn(input string name);
        tick(1);
        chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({name, "_tx_left"},  32'(exp_tx.size()),  32'd0);
    endtask

    // Monitor: compares every request and every delivered instruction
    initial begin
        logic [31:0]  ea;
        fetch_entry_t et;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: got addr %08h want none", imem_addr);
                end else begin
                    ea = exp_req.pop_front();
                    chk("imem_addr", imem_addr, ea);
                end
            end
            if (if_valid && if_ready) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got pc %08h instr %08h want none", if_pc, if_instr);
                end else begin
                    et = exp_tx.pop_front();
                    chk("if_pc", if_pc, et.pc);
                    chk("if_instr", if_instr, et.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc",    if_pc,    32'd0);
        chk("rst_fetch_pc", fetch_pc, RST_PC);

        // Startup stream
        if_ready = 1'b1;
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_req(32'hC); push_req(32'h10); push_req(32'h14);
        push_tx(32'h0, W0); push_tx(32'h4, W1); push_tx(32'h8, W2); push_tx(32'hC, W3);
        rst_n = 1'b1;
        #1 chk("s1_valid_c0", 32'(if_valid), 32'd0);
        tick(1); chk("s1_valid_c1", 32'(if_valid), 32'd0);
        tick(1); chk("s1_valid_c2", 32'(if_valid), 32'd1);
        tick(4);
        rst_n = 1'b0;
        end_scn("s1");

        // Backpressure then drain
        if_ready = 1'b0;
        push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
        push_req(32'h10); push_req(32'h14); push_req(32'h18);
        push_tx(32'h0, W0); push_tx(32'h4, W1); push_tx(32'h8, W2); push_tx(32'hC, W3);
        rst_n = 1'b1;
        tick(4);
        chk("s2_full_req", 32'(imem_req), 32'd0);
        chk("s2_head_pc", if_pc, 32'h0);
        chk("s2_head_instr", if_instr, W0);
        tick(3);
        chk("s2_hold_req", 32'(imem_req), 32'd0);
        chk("s2_hold_pc", if_pc, 32'h0);
        chk("s2_hold_instr", if_instr, W0);
        tick(1);
        if_ready = 1'b1;
        tick(4);
        rst_n = 1'b0;
        end_scn("s2");

        // Redirect with a read in flight
        if_ready = 1'b1;
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_req(32'hC); push_req(32'h10); push_req(32'h14);
        push_tx(32'h0, W0); push_tx(32'h4, W1); push_tx(32'hC, W3);
        rst_n = 1'b1;
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000C;
        #1 chk("s3_no_issue", 32'(imem_req), 32'd0);
        tick(1);
        redirect_valid = 1'b0;
        chk("s3_empty", 32'(if_valid), 32'd0);
        chk("s3_addr", imem_addr, 32'hC);
        tick(3);
        rst_n = 1'b0;
        end_scn("s3");

        // Redirect coinciding with a handshake on a full FIFO
        if_ready = 1'b0;
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_req(32'hC); push_req(32'h10); push_req(32'h14);
        push_tx(32'h0, W0);
        rst_n = 1'b1;
        tick(6);
        chk("s4_full_valid", 32'(if_valid), 32'd1);
        chk("s4_full_req", 32'(imem_req), 32'd0);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0013;
        tick(1);
        redirect_valid = 1'b0;
        chk("s4_flushed", 32'(if_valid), 32'd0);
        chk("s4_fetch_pc", fetch_pc, 32'h10);
        tick(2);
        rst_n = 1'b0;
        end_scn("s4");

        // Address wrap
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        push_req(32'hFFFF_FFF8); push_req(32'hFFFF_FFFC);
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_tx(32'hFFFF_FFF8, 32'h2152_FFF8);
        push_tx(32'hFFFF_FFFC, 32'h2152_FFFC);
        push_tx(32'h0, W0);
        rst_n = 1'b1;
        #1 chk("s5_no_issue", 32'(imem_req), 32'd0);
        tick(1);
        redirect_valid = 1'b0;
        tick(5);
        rst_n = 1'b0;
        end_scn("s5");

        // Asynchronous reset with three entries buffered
        if_ready = 1'b0;
        push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
        rst_n = 1'b1;
        tick(4);
        chk("s6_pre_valid", 32'(if_valid), 32'd1);
        chk("s6_pre_pc", if_pc, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_valid", 32'(if_valid), 32'd0);
        chk("s6_async_req", 32'(imem_req), 32'd0);
        chk("s6_async_pc", if_pc, 32'd0);
        tick(2);
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_tx(32'h0, W0);
        if_ready = 1'b1;
        rst_n    = 1'b1;
        #1 chk("s6_restart_valid", 32'(if_valid), 32'd0);
        chk("s6_restart_addr", imem_addr, RST_PC);
        tick(3);
        rst_n = 1'b0;
        end_scn("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
